uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//   Serial-to-parallel UART receive path: 8N1 frames (start, 8 data LSB-first, 1 stop).
//   Counterpart of the UART transmitter; drives RBR toward the host side of the UART.
//   bclk runs at OVERSAMPLE x baud. Each bit is sampled once, at its centre.
//   Flags data-ready, framing error and overrun, each held until the host reads.
// PARAMETERS
//   DATA_BITS   8    data bits per frame (LSB first)
//   OVERSAMPLE  16   bclk cycles per bit; must be even and >= 4
// PORTS
//   bclk         in   1          sample clock, OVERSAMPLE x baud, rising edge
//   rst          in   1          asynchronous, active-high reset
//   rx_data      in   1          serial line, idle high, asynchronous to bclk
//   rx_rd        in   1          1-cycle pulse: host has read RBR; clears all flags
//   RBR          out  DATA_BITS  received data register
//   rx_status    out  1          1 = RBR holds unread data
//   framing_err  out  1          1 = last loaded frame had stop bit = 0
//   overrun_err  out  1          1 = a frame completed while rx_status was 1
//   rx_busy      out  1          1 = state other than IDLE
// BEHAVIOUR
//   Reset: RBR=0, all flags 0, rx_busy=0, state IDLE. Synchronizer flops reset to 1.
//   Reset mid-frame aborts the frame; nothing is loaded.
//   rx_data passes through a 2-flop synchronizer (rxs) before any use.
//   Tick counter cnt counts 0..OVERSAMPLE-1. It clears on every state entry.
//   IDLE: rxs=0 -> START.
//   START: at cnt=OVERSAMPLE/2-1, sample rxs.
//     rxs=1 -> IDLE (glitch; no flag).
//     rxs=0 -> DATA, bit index 0.
//   DATA: every OVERSAMPLE cycles (bit centre), shift rxs into the shift register MSB.
//     Shift right, so LSB-first ends up in the correct order.
//     After DATA_BITS samples -> STOP.
//   STOP: at the centre sample, load RBR with the shift register.
//     Set framing_err = ~rxs. Set rx_status=1.
//     rxs=1 -> IDLE. rxs=0 -> BREAK.
//   BREAK: wait for rxs=1 -> IDLE. Prevents re-triggering on a held-low line.
//   Latency: rx_data falling edge -> rx_status=1 is 2+OVERSAMPLE/2+9*OVERSAMPLE
//     bclk cycles (+1 for synchronizer phase). With defaults: 154 or 155.
//   Overrun: if rx_status=1 at a STOP load, set overrun_err=1.
//     RBR and framing_err keep the old (unread) values; the new frame is dropped.
//   rx_rd: on the next edge, clear rx_status, framing_err and overrun_err.
//   rx_rd in the same cycle as a STOP load: the load wins.
//     rx_status stays 1, RBR gets new data, overrun_err=0.
//   rx_rd while rx_status=0: no effect.
//   All outputs are registered. No combinational path from rx_data or rx_rd to outputs.
// STRUCTURE
//   uart_pkg holds:
//     rx_state_t enum {IDLE, START, DATA, STOP, BREAK};
//     constants UART_DATA_BITS=8, UART_OVERSAMPLE=16.
//   Shared with the transmitter.
//   Sub-module uart_sync2: 2-flop synchronizer, async reset to a parameterized value (1).
//   Everything else (FSM, tick counter, bit index, shift register, flags) lives in this module.
// TESTING
//   Clock: bclk 10 ns. Frames are driven at OVERSAMPLE x 10 ns per bit.
//   1. Frame 0x6C with stop=1
//      -> RBR=0x6C, rx_status=1, framing_err=0, overrun_err=0 at 154/155 cycles.
//   2. rx_data low for 4 cycles, then high
//      -> START aborts to IDLE; rx_status stays 0 and RBR is unchanged.
//   3. Frame 0xA5 with stop=0, line held low 40 bit times
//      -> RBR=0xA5, framing_err=1. rx_busy stays 1 until the line goes high.
//      -> No second frame is received.
//   4. Frame 0x6C, no rx_rd, then frame 0x6D
//      -> overrun_err=1, RBR=0x6C.
//      -> rx_rd pulse then clears all three flags.
//   5. rx_rd pulse on the exact STOP-load cycle of 0x3C
//      -> rx_status=1, RBR=0x3C, overrun_err=0.
//   6. rst=1 during data bit 3 of 0xFF, then frame 0x3C
//      -> all outputs 0 after reset; 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Types and defaults that the UART receiver and transmitter both use.
package uart_pkg;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RST_VAL so an idle-high line reads as idle straight out of reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive path: each bit is sampled once at its centre on an oversampled clock.
// Received data and the ready, framing and overrun flags stay held until the host reads RBR.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 bclk,
    input  logic                 rst,
    input  logic                 rx_data,
    input  logic                 rx_rd,
    output logic [DATA_BITS-1:0] RBR,
    output logic                 rx_status,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic rxs;

    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [DATA_BITS-1:0] rbr_q, rbr_d;
    logic                 status_q, status_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk_i (bclk),
        .rst_i (rst),
        .d_i   (rx_data),
        .q_o   (rxs)
    );

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            sr_q     <= '0;
            rbr_q    <= '0;
            status_q <= 1'b0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sr_q     <= sr_d;
            rbr_q    <= rbr_d;
            status_q <= status_d;
            fe_q     <= fe_d;
            ov_q     <= ov_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == FULL_M1) ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        sr_d     = sr_q;
        rbr_d    = rbr_q;
        status_d = status_q;
        fe_d     = fe_q;
        ov_d     = ov_q;

        if (rx_rd) begin
            status_d = 1'b0;
            fe_d     = 1'b0;
            ov_d     = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rxs) state_d = START;
            end
            START: begin
                idx_d = '0;
                if (cnt_q == HALF_M1) state_d = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    sr_d  = {rxs, sr_q[DATA_BITS-1:1]};
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    // A read landing on the load cycle frees RBR, so the new frame is taken.
                    if (status_q && !rx_rd) begin
                        ov_d = 1'b1;
                    end else begin
                        rbr_d    = sr_q;
                        fe_d     = ~rxs;
                        status_d = 1'b1;
                        ov_d     = 1'b0;
                    end
                    state_d = rxs ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    assign RBR         = rbr_q;
    assign rx_status   = status_q;
    assign framing_err = fe_q;
    assign overrun_err = ov_q;
    assign rx_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames
// checked against a frame-level model of the host-visible registers.
module tb_uart_receiver;
    localparam int OS    = 16;
    localparam int BIT_T = OS * 10;

    logic       bclk = 1'b0;
    logic       rst;
    logic       rx_data;
    logic       rx_rd;
    logic [7:0] RBR;
    logic       rx_status;
    logic       framing_err;
    logic       overrun_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_rbr;
    logic       m_st, m_fe, m_ov;

    uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .bclk        (bclk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_rd       (rx_rd),
        .RBR         (RBR),
        .rx_status   (rx_status),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .rx_busy     (rx_busy)
    );

    always #5 bclk = ~bclk;

    task automatic model_reset();
        m_rbr = 8'h00; m_st = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    endtask

    // One completed frame as the host sees it.
    task automatic model_frame(input logic [7:0] d, input logic stop, input logic rd_same);
        if (m_st && !rd_same) begin
            m_ov = 1'b1;
        end else begin
            m_rbr = d; m_fe = !stop; m_st = 1'b1; m_ov = 1'b0;
        end
    endtask

    task automatic model_read();
        m_st = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    endtask

    // Caller aligns to a negedge first; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_data = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            rx_data = d[i];
            #(BIT_T);
        end
        rx_data = stop;
        #(BIT_T);
    endtask

    task automatic host_read();
        @(negedge bclk); rx_rd = 1'b1;
        @(negedge bclk); rx_rd = 1'b0;
        model_read();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_data = 1'b1; rx_rd = 1'b0;
        model_reset();
        repeat (3) @(negedge bclk);
        checks++;
        if ({RBR, rx_status, framing_err, overrun_err, rx_busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", {RBR, rx_status, framing_err, overrun_err, rx_busy}, 12'h000);
        end
        rst = 1'b0;
        repeat (5) @(negedge bclk);
        checks++;
        if ({RBR, rx_status, framing_err, overrun_err, rx_busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", {RBR, rx_status, framing_err, overrun_err, rx_busy}, 12'h000);
        end
    endtask

    task automatic test_latency();
        int n;
        n = 0;
        @(negedge bclk);
        fork
            send_frame(8'h6C, 1'b1);
            begin
                while (!rx_status && n < 300) begin
                    @(posedge bclk); #1;
                    n++;
                end
            end
        join
        model_frame(8'h6C, 1'b1, 1'b0);
        checks++;
        if (n < 154 || n > 155) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected 154..155", n);
        end
        checks++;
        if ({RBR, rx_status, framing_err, overrun_err} !== {m_rbr, m_st, m_fe, m_ov}) begin
            errors++;
            $display("FAIL frame_6C: got %h expected %h", {RBR, rx_status, framing_err, overrun_err}, {m_rbr, m_st, m_fe, m_ov});
        end
    endtask

    task automatic test_glitch();
        host_read();
        @(negedge bclk); rx_data = 1'b0;
        repeat (4) @(negedge bclk);
        rx_data = 1'b1;
        repeat (30) @(negedge bclk);
        checks++;
        if ({RBR, rx_status, framing_err, overrun_err, rx_busy} !== {m_rbr, m_st, m_fe, m_ov, 1'b0}) begin
            errors++;
            $display("FAIL glitch: got %h expected %h", {RBR, rx_status, framing_err, overrun_err, rx_busy}, {m_rbr, m_st, m_fe, m_ov, 1'b0});
        end
    endtask

    task automatic test_break();
        @(negedge bclk);
        send_frame(8'hA5, 1'b0);
        model_frame(8'hA5, 1'b0, 1'b0);
        checks++;
        if ({RBR, rx_status, framing_err, overrun_err} !== {m_rbr, m_st, m_fe, m_ov}) begin
            errors++;
            $display("FAIL break_frame: got %h expected %h", {RBR, rx_status, framing_err, overrun_err}, {m_rbr, m_st, m_fe, m_ov});
        end
        for (int k = 0; k < 4; k++) begin
            repeat (10 * OS) @(negedge bclk);
            checks++;
            if ({rx_busy, RBR, rx_status, framing_err, overrun_err} !== {1'b1, m_rbr, m_st, m_fe, m_ov}) begin
                errors++;
                $display("FAIL break_hold_%0d: got %h expected %h", k, {rx_busy, RBR, rx_status, framing_err, overrun_err}, {1'b1, m_rbr, m_st, m_fe, m_ov});
            end
        end
        rx_data = 1'b1;
        repeat (4) @(negedge bclk);
        checks++;
        if ({rx_busy, RBR, rx_status, framing_err, overrun_err} !== {1'b0, m_rbr, m_st, m_fe, m_ov}) begin
            errors++;
            $display("FAIL break_release: got %h expected %h", {rx_busy, RBR, rx_status, framing_err, overrun_err}, {1'b0, m_rbr, m_st, m_fe, m_ov});
        end
    endtask

    task automatic test_overrun();
        host_read();
        repeat (3) @(negedge bclk);
        send_frame(8'h6C, 1'b1);
        model_frame(8'h6C, 1'b1, 1'b0);
        repeat (3) @(negedge bclk);
        send_frame(8'h6D, 1'b1);
        model_frame(8'h6D, 1'b1, 1'b0);
        checks++;
        if ({RBR, rx_status, framing_err, overrun_err} !== {8'h6C, 3'b101}) begin
            errors++;
            $display("FAIL overrun: got %h expected %h", {RBR, rx_status, framing_err, overrun_err}, {8'h6C, 3'b101});
        end
        checks++;
        if ({RBR, rx_status, framing_err, overrun_err} !== {m_rbr, m_st, m_fe, m_ov}) begin
            errors++;
            $display("FAIL overrun_model: got %h expected %h", {RBR, rx_status, framing_err, overrun_err}, {m_rbr, m_st, m_fe, m_ov});
        end
        host_read();
        checks++;
        if ({RBR, rx_status, framing_err, overrun_err} !== {8'h6C, 3'b000}) begin
            errors++;
            $display("FAIL overrun_clear: got %h expected %h", {RBR, rx_status, framing_err, overrun_err}, {8'h6C, 3'b000});
        end
    endtask

    task automatic test_read_on_load();
        // Leave an unread frame so the coincident read is the only thing avoiding overrun.
        repeat (3) @(negedge bclk);
        send_frame(8'h55, 1'b1);
        model_frame(8'h55, 1'b1, 1'b0);
        repeat (3) @(negedge bclk);
        fork
            send_frame(8'h3C, 1'b1);
            begin
                repeat (154) @(posedge bclk);
                @(negedge bclk); rx_rd = 1'b1;
                @(negedge bclk); rx_rd = 1'b0;
            end
        join
        model_frame(8'h3C, 1'b1, 1'b1);
        checks++;
        if ({RBR, rx_status, framing_err, overrun_err} !== {m_rbr, m_st, m_fe, m_ov}) begin
            errors++;
            $display("FAIL read_on_load: got %h expected %h", {RBR, rx_status, framing_err, overrun_err}, {m_rbr, m_st, m_fe, m_ov});
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge bclk);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                #(BIT_T * 4 + BIT_T / 2);
                rst = 1'b1;
                model_reset();
                repeat (3) @(negedge bclk);
                checks++;
                if ({RBR, rx_status, framing_err, overrun_err, rx_busy} !== 12'h000) begin
                    errors++;
                    $display("FAIL mid_reset: got %h expected %h", {RBR, rx_status, framing_err, overrun_err, rx_busy}, 12'h000);
                end
                rst = 1'b0;
            end
        join
        repeat (20) @(negedge bclk);
        checks++;
        if ({RBR, rx_status, framing_err, overrun_err, rx_busy} !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset_after: got %h expected %h", {RBR, rx_status, framing_err, overrun_err, rx_busy}, 12'h000);
        end
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1, 1'b0);
        checks++;
        if ({RBR, rx_status, framing_err, overrun_err} !== {m_rbr, m_st, m_fe, m_ov}) begin
            errors++;
            $display("FAIL mid_reset_recover: got %h expected %h", {RBR, rx_status, framing_err, overrun_err}, {m_rbr, m_st, m_fe, m_ov});
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       stop;
        for (int it = 0; it < 20; it++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) host_read();
            repeat ($urandom_range(2, 20)) @(negedge bclk);
            send_frame(d, stop);
            model_frame(d, stop, 1'b0);
            if (!stop) begin
                repeat ($urandom_range(1, 40)) @(negedge bclk);
                rx_data = 1'b1;
            end
            repeat (4) @(negedge bclk);
            checks++;
            if ({rx_busy, RBR, rx_status, framing_err, overrun_err} !== {1'b0, m_rbr, m_st, m_fe, m_ov}) begin
                errors++;
                $display("FAIL random_%0d data %h stop %0d: got %h expected %h", it, d, stop,
                         {rx_busy, RBR, rx_status, framing_err, overrun_err}, {1'b0, m_rbr, m_st, m_fe, m_ov});
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_break();
        test_overrun();
        test_read_on_load();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
